// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Requester-side front end for the data memory. Accepts load/store
//             requests over valid/ready, drives memory enable/address/data,
//             bounds-checks addresses and returns load data after a fixed
//             read latency on a valid/ready response channel.
//  Options  : define MAU_PERF_CNT_EN to add saturating load/store/fault
//             response counters (load_count, store_count, fault_count).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int MEM_DEPTH    = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MAU_PERF_CNT_EN
   ,
   output logic [15:0]       load_count,
   output logic [15:0]       store_count,
   output logic [7:0]        fault_count
`endif
);

   // One extra bit so MEM_DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [2:0]      c_LAT   = 3'(READ_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;
   logic [2:0]        cnt_q, cnt_d;

   logic              w_accept;
   logic              w_fault;

   assign req_ready  = (state_q == S_IDLE);
   assign w_accept   = req_valid && (state_q == S_IDLE);
   assign w_fault    = ({1'b0, req_addr} >= c_DEPTH);

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

   // State and registered outputs; async reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic: everything holds by default, write enable self-clears.
   always_comb begin
      state_d      = state_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               mem_addr_d  = req_addr;
               mem_wdata_d = req_wdata;
               if (w_fault) begin
                  // Out-of-range: answer immediately, memory is never touched.
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_data_d  = '0;
                  state_d      = S_RESP;
               end else if (req_write) begin
                  mem_we_d = 1'b1;
                  state_d  = S_WRITE;
               end else begin
                  cnt_d   = c_LAT;
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = '0;
            state_d      = S_RESP;
         end
         S_READ: begin
            // Address stays put; read data is valid on the last counted edge.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               resp_data_d  = mem_rdata;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MAU_PERF_CNT_EN
   localparam logic [1:0] c_OP_LOAD  = 2'd0;
   localparam logic [1:0] c_OP_STORE = 2'd1;
   localparam logic [1:0] c_OP_FAULT = 2'd2;

   logic [1:0]  op_q;
   logic [15:0] load_cnt_q;
   logic [15:0] store_cnt_q;
   logic [7:0]  fault_cnt_q;
   logic        w_consume;

   assign w_consume   = (state_q == S_RESP) && resp_ready;
   assign load_count  = load_cnt_q;
   assign store_count = store_cnt_q;
   assign fault_count = fault_cnt_q;

   // Remember the kind of the accepted request until its response is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= c_OP_LOAD;
      end else if (w_accept) begin
         op_q <= w_fault ? c_OP_FAULT : (req_write ? c_OP_STORE : c_OP_LOAD);
      end
   end

   // Saturating counters stepped when a response leaves the unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         fault_cnt_q <= '0;
      end else if (w_consume) begin
         if (op_q == c_OP_LOAD && load_cnt_q != 16'hFFFF)
            load_cnt_q <= load_cnt_q + 16'd1;
         if (op_q == c_OP_STORE && store_cnt_q != 16'hFFFF)
            store_cnt_q <= store_cnt_q + 16'd1;
         if (op_q == c_OP_FAULT && fault_cnt_q != 8'hFF)
            fault_cnt_q <= fault_cnt_q + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. Two instances: one with
//             READ_LATENCY=1, one with READ_LATENCY=3, each with a memory
//             model whose read data is valid READ_LATENCY edges after the
//             unit presents the address. Latencies are counted in clock edges
//             with the accept edge as edge 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // ---------------- READ_LATENCY = 1 instance ----------------
   logic       req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, mem_we;
   logic [7:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
`ifdef MAU_PERF_CNT_EN
   logic [15:0] load_count, store_count, r3_load_count, r3_store_count;
   logic [7:0]  fault_count, r3_fault_count;
   int exp_ld, exp_st, exp_ft;
`endif

   mem_access_unit #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MAU_PERF_CNT_EN
      , .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
`endif
   );

   // ---------------- READ_LATENCY = 3 instance ----------------
   logic       r3_req_valid, r3_req_ready, r3_req_write, r3_resp_valid, r3_resp_ready, r3_resp_err, r3_mem_we;
   logic [7:0] r3_req_addr, r3_req_wdata, r3_resp_data, r3_mem_addr, r3_mem_wdata, r3_mem_rdata;

   mem_access_unit #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(DEPTH), .READ_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid(r3_req_valid), .req_ready(r3_req_ready), .req_write(r3_req_write),
      .req_addr(r3_req_addr), .req_wdata(r3_req_wdata),
      .resp_valid(r3_resp_valid), .resp_ready(r3_resp_ready), .resp_data(r3_resp_data), .resp_err(r3_resp_err),
      .mem_we(r3_mem_we), .mem_addr(r3_mem_addr), .mem_wdata(r3_mem_wdata), .mem_rdata(r3_mem_rdata)
`ifdef MAU_PERF_CNT_EN
      , .load_count(r3_load_count), .store_count(r3_store_count), .fault_count(r3_fault_count)
`endif
   );

   // Initial memory image shared by both memory models and the reference.
   function automatic logic [7:0] init_val(input int i);
      if (i == 3)  return 8'h3C;
      if (i == 16) return 8'h5A;
      return 8'(i * 37 + 11);
   endfunction

   // Memory models: synchronous write; read valid after READ_LATENCY edges.
   logic [7:0] mem1 [0:255];
   logic [7:0] mem3 [0:255];
   logic [7:0] p3 [0:1];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem1[i] <= init_val(i);
      end else if (mem_we) begin
         mem1[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem1[mem_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem3[i] <= init_val(i);
      end else if (r3_mem_we) begin
         mem3[r3_mem_addr] <= r3_mem_wdata;
      end
      p3[0] <= mem3[r3_mem_addr];
      p3[1] <= p3[0];
   end
   assign r3_mem_rdata = p3[1];

   // Reference memory contents, updated only from the bench's own transactions.
   logic [7:0] ref_mem [0:DEPTH-1];

   // One transaction on the READ_LATENCY=1 instance; returns observations only.
   task automatic txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdat, input int hold,
                      output int lat, output logic [7:0] rdat, output logic err, output int we_cnt,
                      output bit we_ok, output bit hold_ok, output bit post_ok);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdat;
      @(posedge clk);
      @(negedge clk);
      // Scramble request fields after accept; they must not matter any more.
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
      lat = 1; we_cnt = 0; we_ok = 1'b1;
      while (resp_valid !== 1'b1 && lat < 40) begin
         if (mem_we === 1'b1) begin
            we_cnt++;
            if (mem_addr !== addr || mem_wdata !== wdat) we_ok = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (mem_we !== 1'b0) we_cnt++;
      rdat = resp_data; err = resp_err;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_data !== rdat || resp_err !== err ||
             req_ready !== 1'b0 || mem_we !== 1'b0) hold_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      post_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
      if (addr < 8'(DEPTH) && wr) ref_mem[addr[4:0]] = wdat;
`ifdef MAU_PERF_CNT_EN
      if (addr >= 8'(DEPTH)) exp_ft++; else if (wr) exp_st++; else exp_ld++;
`endif
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00)
         begin n_fail++; $display("FAIL rst_mem got we=%b addr=%h wdata=%h exp 0/00/00", mem_we, mem_addr, mem_wdata); end
      n_checks++; if (resp_data !== 8'h00 || resp_err !== 1'b0)
         begin n_fail++; $display("FAIL rst_resp got data=%h err=%b exp 00/0", resp_data, resp_err); end
      // Requests presented while reset is held must be ignored.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'h77;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL rst_no_accept got we=%b addr=%h valid=%b exp 0/00/0", mem_we, mem_addr, resp_valid); end
      req_valid = 1'b0; mem_init = 1'b0; rst = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL post_rst got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
   endtask

   task automatic test_store_load();
      int lat, wec; logic [7:0] d; logic e; bit wok, hok, pok;
      txn(1'b1, 8'h05, 8'hA7, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (lat !== 2)     begin n_fail++; $display("FAIL st_latency got %0d exp 2", lat); end
      n_checks++; if (wec !== 1)     begin n_fail++; $display("FAIL st_we_cycles got %0d exp 1", wec); end
      n_checks++; if (wok !== 1'b1)  begin n_fail++; $display("FAIL st_we_addr_data got %b exp 1", wok); end
      n_checks++; if (e !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL st_resp got err=%b data=%h exp 0/00", e, d); end
      n_checks++; if (pok !== 1'b1)  begin n_fail++; $display("FAIL st_consume got %b exp 1", pok); end
      txn(1'b0, 8'h05, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (lat !== 2)     begin n_fail++; $display("FAIL ld_latency got %0d exp 2", lat); end
      n_checks++; if (d !== 8'hA7 || e !== 1'b0) begin n_fail++; $display("FAIL ld_data got %h err=%b exp A7/0", d, e); end
      n_checks++; if (wec !== 0)     begin n_fail++; $display("FAIL ld_we got %0d exp 0", wec); end
   endtask

   task automatic test_bounds();
      int lat, wec; logic [7:0] d; logic e; bit wok, hok, pok;
      txn(1'b0, 8'h20, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (e !== 1'b1 || d !== 8'h00) begin n_fail++; $display("FAIL ld20_err got err=%b data=%h exp 1/00", e, d); end
      n_checks++; if (wec !== 0 || lat !== 1) begin n_fail++; $display("FAIL ld20_we_lat got we=%0d lat=%0d exp 0/1", wec, lat); end
      txn(1'b1, 8'h1F, 8'hC4, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (e !== 1'b0 || lat !== 2 || wec !== 1 || wok !== 1'b1)
         begin n_fail++; $display("FAIL st1F got err=%b lat=%0d we=%0d ok=%b exp 0/2/1/1", e, lat, wec, wok); end
      txn(1'b0, 8'h1F, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (d !== 8'hC4 || e !== 1'b0) begin n_fail++; $display("FAIL ld1F got %h err=%b exp C4/0", d, e); end
      txn(1'b1, 8'hFF, 8'h11, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (e !== 1'b1 || wec !== 0) begin n_fail++; $display("FAIL stFF got err=%b we=%0d exp 1/0", e, wec); end
      n_checks++; if (mem1[255] !== init_val(255)) begin n_fail++; $display("FAIL stFF_mem got %h exp %h", mem1[255], init_val(255)); end
   endtask

   task automatic test_backpressure();
      int lat, wec; logic [7:0] d; logic e; bit wok, hok, pok;
      txn(1'b0, 8'h03, 8'h00, 5, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (d !== 8'h3C || e !== 1'b0) begin n_fail++; $display("FAIL bp_data got %h err=%b exp 3C/0", d, e); end
      n_checks++; if (hok !== 1'b1) begin n_fail++; $display("FAIL bp_hold got %b exp 1", hok); end
      n_checks++; if (pok !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", pok); end
   endtask

   task automatic test_latency();
      int n;
      for (int k = 0; k < 2; k++) begin
         logic [7:0] a, ex;
         a  = (k == 0) ? 8'h10 : 8'h03;
         ex = (k == 0) ? 8'h5A : 8'h3C;
         @(negedge clk);
         r3_req_valid = 1'b1; r3_req_write = 1'b0; r3_req_addr = a;
         @(posedge clk);
         @(negedge clk);
         r3_req_valid = 1'b0; r3_req_addr = 8'($urandom);
         n = 1;
         while (r3_resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
         n_checks++; if (n !== 4) begin n_fail++; $display("FAIL rl3_latency addr %h got %0d exp 4", a, n); end
         n_checks++; if (r3_resp_data !== ex || r3_resp_err !== 1'b0)
            begin n_fail++; $display("FAIL rl3_data addr %h got %h err=%b exp %h/0", a, r3_resp_data, r3_resp_err, ex); end
         r3_resp_ready = 1'b1;
         @(negedge clk);
         r3_resp_ready = 1'b0;
         n_checks++; if (r3_resp_valid !== 1'b0 || r3_req_ready !== 1'b1)
            begin n_fail++; $display("FAIL rl3_consume got valid=%b ready=%b exp 0/1", r3_resp_valid, r3_req_ready); end
      end
   endtask

   task automatic test_reset_mid();
      int lat, wec; logic [7:0] d; logic e; bit wok, hok, pok, idle_ok;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_before got %b exp 1", mem_we); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL mid_async got we=%b valid=%b exp 0/0", mem_we, resp_valid); end
      @(negedge clk);
      rst = 1'b0;
`ifdef MAU_PERF_CNT_EN
      exp_ld = 0; exp_st = 0; exp_ft = 0;
`endif
      idle_ok = (req_ready === 1'b1);
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) idle_ok = 1'b0;
      end
      n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL mid_idle got %b exp 1", idle_ok); end
      txn(1'b0, 8'h05, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (d !== 8'hA7 || lat !== 2) begin n_fail++; $display("FAIL mid_reload got %h lat=%0d exp A7/2", d, lat); end
      txn(1'b0, 8'h07, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (d !== ref_mem[7]) begin n_fail++; $display("FAIL mid_nowrite got %h exp %h", d, ref_mem[7]); end
   endtask

   task automatic test_random();
      int lat, wec, hold; logic [7:0] d, a, w, exd; logic e; bit wr, flt, wok, hok, pok;
      for (int t = 0; t < 40; t++) begin
         a    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
         w    = 8'($urandom);
         wr   = 1'($urandom);
         hold = int'($urandom_range(0, 2));
         flt  = (a >= 8'(DEPTH));
         exd  = (flt || wr) ? 8'h00 : ref_mem[a[4:0]];
         txn(wr, a, w, hold, lat, d, e, wec, wok, hok, pok);
         n_checks++; if (lat !== (flt ? 1 : 2))
            begin n_fail++; $display("FAIL rnd%0d_latency wr=%b addr=%h got %0d exp %0d", t, wr, a, lat, flt ? 1 : 2); end
         n_checks++; if (d !== exd || e !== flt)
            begin n_fail++; $display("FAIL rnd%0d_resp wr=%b addr=%h got %h/%b exp %h/%b", t, wr, a, d, e, exd, flt); end
         n_checks++; if (wec !== ((!flt && wr) ? 1 : 0) || wok !== 1'b1)
            begin n_fail++; $display("FAIL rnd%0d_we wr=%b addr=%h got %0d ok=%b", t, wr, a, wec, wok); end
         n_checks++; if (hok !== 1'b1 || pok !== 1'b1)
            begin n_fail++; $display("FAIL rnd%0d_handshake got hold=%b post=%b exp 1/1", t, hok, pok); end
      end
`ifdef MAU_PERF_CNT_EN
      n_checks++; if (load_count !== 16'(exp_ld) || store_count !== 16'(exp_st) || fault_count !== 8'(exp_ft))
         begin n_fail++; $display("FAIL rnd_counters got %0d/%0d/%0d exp %0d/%0d/%0d",
                                  load_count, store_count, fault_count, exp_ld, exp_st, exp_ft); end
`endif
   endtask

`ifdef MAU_PERF_CNT_EN
   task automatic test_perf();
      int lat, wec; logic [7:0] d; logic e; bit wok, hok, pok;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_ld = 0; exp_st = 0; exp_ft = 0;
      txn(1'b1, 8'h0A, 8'h21, 0, lat, d, e, wec, wok, hok, pok);
      txn(1'b1, 8'h0B, 8'h22, 1, lat, d, e, wec, wok, hok, pok);
      txn(1'b0, 8'h0A, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      txn(1'b0, 8'h0B, 8'h00, 2, lat, d, e, wec, wok, hok, pok);
      txn(1'b0, 8'h03, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      txn(1'b0, 8'h40, 8'h00, 0, lat, d, e, wec, wok, hok, pok);
      n_checks++; if (store_count !== 16'd2 || load_count !== 16'd3 || fault_count !== 8'd1)
         begin n_fail++; $display("FAIL perf_counts got st=%0d ld=%0d ft=%0d exp 2/3/1", store_count, load_count, fault_count); end
      @(negedge clk); rst = 1'b1;
      #1;
      n_checks++; if (store_count !== 16'd0 || load_count !== 16'd0 || fault_count !== 8'd0)
         begin n_fail++; $display("FAIL perf_reset got st=%0d ld=%0d ft=%0d exp 0/0/0", store_count, load_count, fault_count); end
      @(negedge clk); rst = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; resp_ready = 1'b0;
      r3_req_valid = 1'b0; r3_req_write = 1'b0; r3_req_addr = 8'h00; r3_req_wdata = 8'h00; r3_resp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
`ifdef MAU_PERF_CNT_EN
      exp_ld = 0; exp_st = 0; exp_ft = 0;
`endif
      test_reset();
      test_store_load();
      test_bounds();
      test_backpressure();
      test_latency();
      test_reset_mid();
      test_random();
`ifdef MAU_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
